op_host_seq: RTL and testbench

//  Host-side initiator for the iterative operation engine (IDLE/EXEC/DONE controller, 16 exec cycles).

---
 rtl/op_host_seq.sv | 102 ++++++++++
 tb/tb_op_host_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_host_seq.sv
// Host-side initiator for the iterative operation engine: takes an operand request,
// runs one start/wait/response cycle on the engine, and cleans up aborts and timeouts.
module op_host_seq #(
  parameter int DATA_W  = 32,
  parameter int RES_W   = 64,
  parameter int TIMEOUT = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              abort,
  output logic              eng_op_start,
  output logic              eng_op_clear,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  input  logic              eng_op_done,
  input  logic [RES_W-1:0]  eng_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_error,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_CLEAR = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Last WAIT cycle index before the operation is declared timed out.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              state_q;
  logic [7:0]          timer_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [RES_W-1:0]    res_q;
  logic                err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            state_q <= S_START;
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= abort ? S_CLEAR : S_WAIT;
        end
        S_WAIT: begin
          if (timer_q != 8'hFF) timer_q <= timer_q + 8'd1;
          // A completing engine wins over a simultaneous abort or timeout.
          if (eng_op_done) begin
            res_q   <= eng_result;
            err_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (abort || (timer_q == TMO_LAST)) begin
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          res_q   <= '0;
          err_q   <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Every output is a register or a decode of the registered state.
  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign eng_op_start = (state_q == S_START);
  assign eng_op_clear = (state_q == S_CLEAR);
  assign rsp_valid    = (state_q == S_RESP);
  assign eng_a        = a_q;
  assign eng_b        = b_q;
  assign rsp_result   = res_q;
  assign rsp_error    = err_q;

endmodule

// File: tb/tb_op_host_seq.sv
// Bench for op_host_seq: directed scenarios with literal expectations plus a random phase,
// all cross-checked every cycle against a transaction-level model of the sequencer.
module tb_op_host_seq;
  localparam int DATA_W  = 32;
  localparam int RES_W   = 64;
  localparam int TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_a = '0;
  logic [DATA_W-1:0] req_b = '0;
  logic              abort = 1'b0;
  logic              eng_op_start;
  logic              eng_op_clear;
  logic [DATA_W-1:0] eng_a;
  logic [DATA_W-1:0] eng_b;
  logic              eng_op_done = 1'b0;
  logic [RES_W-1:0]  eng_result = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_error;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  logic              e_req_ready, e_start, e_clear, e_rsp_valid, e_busy, e_err;
  logic [DATA_W-1:0] e_a, e_b;
  logic [RES_W-1:0]  e_res;

  always #5 clk = ~clk;

  op_host_seq #(.DATA_W(DATA_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .abort(abort),
    .eng_op_start(eng_op_start), .eng_op_clear(eng_op_clear),
    .eng_a(eng_a), .eng_b(eng_b),
    .eng_op_done(eng_op_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy)
  );

  function automatic void chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level reference model ----------------
  task automatic tick(output bit hit_rst);
    @(posedge clk or negedge reset_n);
    hit_rst = !reset_n;
  endtask

  task automatic set_idle();
    e_req_ready = 1'b1; e_busy = 1'b0; e_start = 1'b0; e_clear = 1'b0; e_rsp_valid = 1'b0;
  endtask

  task automatic model_reset();
    set_idle();
    e_a = '0; e_b = '0; e_res = '0; e_err = 1'b0;
  endtask

  // One operation per loop pass; returns as soon as reset is seen.
  task automatic model_run();
    bit r;
    bit bad;
    int n;
    forever begin
      set_idle();
      do begin tick(r); if (r) return; end while (!req_valid);
      e_a = req_a; e_b = req_b;
      e_req_ready = 1'b0; e_busy = 1'b1; e_start = 1'b1;
      tick(r); if (r) return;
      e_start = 1'b0;
      bad = abort;
      if (!bad) begin
        n = 0;
        forever begin
          tick(r); if (r) return;
          if (eng_op_done) begin e_res = eng_result; e_err = 1'b0; break; end
          if (abort || n == TIMEOUT - 1) begin bad = 1'b1; break; end
          n++;
        end
      end
      if (bad) begin
        e_clear = 1'b1;
        tick(r); if (r) return;
        e_clear = 1'b0; e_res = '0; e_err = 1'b1;
      end
      e_rsp_valid = 1'b1;
      do begin tick(r); if (r) return; end while (!rsp_ready);
    end
  endtask

  initial begin
    forever begin
      model_reset();
      wait (reset_n === 1'b1);
      model_run();
    end
  end

  always @(negedge clk) begin
    chk1("m_req_ready", req_ready, e_req_ready);
    chk1("m_busy", busy, e_busy);
    chk1("m_start", eng_op_start, e_start);
    chk1("m_clear", eng_op_clear, e_clear);
    chk1("m_rsp_valid", rsp_valid, e_rsp_valid);
    chk1("m_rsp_error", rsp_error, e_err);
    chk32("m_eng_a", eng_a, e_a);
    chk32("m_eng_b", eng_b, e_b);
    chk64("m_rsp_result", rsp_result, e_res);
  end

  // ---------------- directed operation driver ----------------
  // t is the cycle index relative to WAIT entry (-1 = START cycle).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int done_at, input int abort_at, input int hold,
                        output logic [63:0] res, output logic err,
                        output int clr_at, output int n_start, output int n_clear);
    int  t;
    bit  seen;
    n_start = 0; n_clear = 0; clr_at = -100; seen = 1'b0;
    rsp_ready = 1'b0; abort = 1'b0; eng_op_done = 1'b0;
    req_valid = 1'b1; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    t = -1;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (eng_op_start) n_start++;
      if (eng_op_clear) begin n_clear++; clr_at = t; end
      if (rsp_valid) seen = 1'b1;
      else begin
        eng_op_done = (t == done_at);
        eng_result  = (t == done_at) ? {32'b0, a} * {32'b0, b} : {$urandom, $urandom};
        abort       = (t == abort_at);
        @(negedge clk);
        t++;
      end
    end
    chk1("rsp_seen_in_bound", seen, 1'b1);
    res = rsp_result; err = rsp_error;
    eng_op_done = 1'b0; abort = 1'b0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_a = $urandom; req_b = $urandom;
      @(negedge clk);
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk64("bp_rsp_result", rsp_result, res);
      chk1("bp_rsp_error", rsp_error, err);
      chk1("bp_req_ready", req_ready, 1'b0);
      chk32("bp_eng_a", eng_a, a);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk1("post_rsp_req_ready", req_ready, 1'b1);
    chk1("post_rsp_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] res;
    logic        err;
    int          clr, ns, nc, eng_cd;

    repeat (3) @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_start", eng_op_start, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk64("rst_rsp_result", rsp_result, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(32'd3, 32'd5, 15, -100, 0, res, err, clr, ns, nc);
    chk64("nominal_result", res, 64'd15);
    chk1("nominal_error", err, 1'b0);
    chki("nominal_starts", ns, 1);
    chki("nominal_clears", nc, 0);

    run_op(32'd7, 32'd9, -100, -100, 0, res, err, clr, ns, nc);
    chki("timeout_clear_cycle", clr, 20);
    chk1("timeout_error", err, 1'b1);
    chk64("timeout_result", res, 64'd0);
    chki("timeout_clears", nc, 1);

    run_op(32'd11, 32'd13, -100, 5, 0, res, err, clr, ns, nc);
    chki("abort_clear_cycle", clr, 6);
    chki("abort_starts", ns, 1);
    chk1("abort_error", err, 1'b1);

    run_op(32'd100, 32'd200, 7, 7, 0, res, err, clr, ns, nc);
    chk64("done_abort_result", res, 64'd20000);
    chk1("done_abort_error", err, 1'b0);
    chki("done_abort_clears", nc, 0);

    run_op(32'd2, 32'd9, 19, -100, 0, res, err, clr, ns, nc);
    chk64("done_at_timeout_result", res, 64'd18);
    chki("done_at_timeout_clears", nc, 0);

    run_op(32'd8, 32'd8, -100, -1, 0, res, err, clr, ns, nc);
    chki("start_abort_clear_cycle", clr, 0);
    chk1("start_abort_error", err, 1'b1);

    run_op(32'd4, 32'd6, 3, -100, 10, res, err, clr, ns, nc);
    chk64("bp_result", res, 64'd24);

    // Reset in the middle of WAIT.
    req_valid = 1'b1; req_a = 32'd21; req_b = 32'd2;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_req_ready", req_ready, 1'b1);
    chk1("arst_clear", eng_op_clear, 1'b0);
    chk32("arst_eng_a", eng_a, 32'd0);
    chk64("arst_rsp_result", rsp_result, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(32'd6, 32'd7, 10, -100, 0, res, err, clr, ns, nc);
    chk64("after_reset_result", res, 64'd42);
    chki("after_reset_clears", nc, 0);

    // Random phase: engine answers after 16 cycles, a random latency, or never.
    eng_cd = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req_valid   = ($urandom_range(0, 9) < 6);
      req_a       = $urandom;
      req_b       = $urandom;
      abort       = ($urandom_range(0, 24) == 0);
      rsp_ready   = 1'($urandom_range(0, 1));
      eng_op_done = 1'b0;
      eng_result  = {$urandom, $urandom};
      if (eng_op_start) begin
        case ($urandom_range(0, 3))
          0:       eng_cd = 16;
          1:       eng_cd = -1;
          default: eng_cd = int'($urandom_range(0, 22));
        endcase
      end else if (eng_op_clear) eng_cd = -1;
      else if (eng_cd == 0) begin
        eng_op_done = 1'b1;
        eng_result  = {32'b0, eng_a} * {32'b0, eng_b};
        eng_cd      = -1;
      end else if (eng_cd > 0) eng_cd--;
      if ($urandom_range(0, 29) == 0) eng_op_done = 1'b1;
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        eng_cd = -1;
      end
    end

    req_valid = 1'b0; abort = 1'b0; eng_op_done = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
